// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;
  localparam int          DEPTH_DEF = 2;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_DRAIN} fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Small ring-buffer FIFO of fetched {pc, instr} pairs; flush dominates push.
module fetch_queue import fetch_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output fetch_entry_t  head,
  output logic          valid,
  output logic [CW-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t [DEPTH-1:0] mem;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign valid   = (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one outstanding imem request, PC control, and a
// small decode-side queue; EX redirects flush the queue and squash responses.
module fetch_unit import fetch_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic [31:0] next_pc,
  output logic        hold_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready
);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t  state, nstate;
  logic [31:0]   req_pc;
  logic [CW-1:0] count;
  logic          hold_c, push, flush;
  fetch_entry_t  head;

  assign imem_req_addr = pc_in;
  assign hold_pc       = reset | hold_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_BOOT;
      req_pc <= '0;
    end else begin
      state <= nstate;
      if (imem_req_valid && imem_req_ready) req_pc <= pc_in;
    end
  end

  always_comb begin
    nstate         = state;
    hold_c         = 1'b1;
    next_pc        = pc_in + PC_STEP;
    imem_req_valid = 1'b0;
    push           = 1'b0;
    flush          = 1'b0;
    case (state)
      S_BOOT: begin
        hold_c = 1'b0;
        nstate = S_REQ;
      end
      S_REQ: begin
        imem_req_valid = (count < CW'(DEPTH)) && !redirect_valid;
        if (imem_req_valid && imem_req_ready) begin
          hold_c = 1'b0;
          nstate = S_WAIT;
        end
      end
      S_WAIT: if (imem_resp_valid) begin
        push   = 1'b1;
        nstate = S_REQ;
      end
      S_DRAIN: if (imem_resp_valid) nstate = S_REQ;
      default: nstate = S_BOOT;
    endcase
    // Redirect wins; a still-pending response must be drained, not queued.
    if (redirect_valid && state != S_BOOT) begin
      next_pc = redirect_pc;
      hold_c  = 1'b0;
      flush   = 1'b1;
      push    = 1'b0;
      nstate  = ((state == S_WAIT || state == S_DRAIN) && !imem_resp_valid) ? S_DRAIN : S_REQ;
    end
  end

  fetch_queue #(.DEPTH(DEPTH), .CW(CW)) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (id_valid && id_ready),
    .flush (flush),
    .din   ('{pc: req_pc, instr: imem_resp_data}),
    .head  (head),
    .valid (id_valid),
    .count (count)
  );

  assign id_pc    = head.pc;
  assign id_instr = head.instr;

  // S_BOOT may legitimately see the tail of a request cut off by reset.
  a_resp_in_req: assert property (@(posedge clk) disable iff (reset)
    imem_resp_valid |-> state != S_REQ);
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined MIPS core, sitting between the program-counter register and the IF/ID boundary. It consumes the current PC, issues one instruction-memory request at a time over a valid/ready handshake, and drives the PC's next value and hold control. Fetched {pc, instruction} pairs are buffered in a small queue and presented to decode with valid/ready flow control. Branch/jump redirects from EX flush the queue and squash any in-flight response.

## Interface
- DEPTH, 2, instruction queue entries (≥1)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- pc_in  in  32  current PC from the program-counter register
- next_pc  out  32  value loaded into the PC when hold_pc=0
- hold_pc  out  1  1 = PC keeps its value this cycle
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  fetch address (= pc_in)
- imem_req_ready  in  1  memory accepts request
- imem_resp_valid  in  1  response data valid (single-cycle pulse)
- imem_resp_data  in  32  instruction word
- redirect_valid  in  1  taken branch/jump resolved in EX
- redirect_pc  in  32  redirect target
- id_valid  out  1  queue head valid to decode
- id_instr  out  32  queue head instruction
- id_pc  out  32  queue head PC
- id_ready  in  1  decode accepts (0 = hazard stall)

## Operation
- States: S_BOOT, S_REQ, S_WAIT, S_DRAIN. Reset → S_BOOT.
- S_BOOT: hold_pc=0, next_pc=pc_in+4 (PC resets to 0xFFFF_FFFC, so first fetch address is 0x0000_0000); → S_REQ next cycle.
- S_REQ: imem_req_valid = (count < DEPTH) & ~redirect_valid. On handshake: capture pc_in into req_pc, hold_pc=0, next_pc=pc_in+4, → S_WAIT. Otherwise hold_pc=1.
- S_WAIT: hold_pc=1. On imem_resp_valid: push {req_pc, imem_resp_data}, → S_REQ.
- S_DRAIN: hold_pc=1. On imem_resp_valid: discard, → S_REQ.
- Redirect (highest priority, any state except S_BOOT): next_pc=redirect_pc, hold_pc=0, queue flushed (count→0, id_valid=0 next cycle). S_WAIT without same-cycle response → S_DRAIN; S_WAIT with same-cycle response → response discarded, → S_REQ; S_REQ/S_DRAIN → S_REQ (S_DRAIN stays S_DRAIN if response still pending).
- Queue: pop on id_valid & id_ready; simultaneous push and pop leaves count unchanged; id_* show head entry, hold stable while id_valid & ~id_ready.
- imem_resp_valid outside S_WAIT/S_DRAIN: ignored (protocol violation, flagged by assertion).
- PC arithmetic modulo 2^32: pc_in=0xFFFF_FFFC gives next_pc=0x0000_0000.

## Timing
- Reset values: state S_BOOT, count 0, id_valid 0, id_instr 0, id_pc 0, req_pc 0, imem_req_valid 0. hold_pc=1 forced while reset is high.
- One outstanding request; response earliest one cycle after handshake.
- Best case (ready=1, 1-cycle memory): handshake cycle N, response N+1, id_valid at N+2; throughput one instruction per 2 cycles.
- redirect_valid → imem_req_valid, hold_pc, next_pc is combinational; all other outputs registered or state-decoded.
- Reset asserted mid-S_WAIT: outstanding response after reset release is ignored (state S_BOOT).

## Structure
- fetch_pkg: state enum, DEPTH default, PC_STEP=4 constant.
- Sub-module fetch_queue: DEPTH-entry synchronous FIFO of 64-bit {pc, instr} with push, pop, flush, count, head outputs; flush dominates push.

## Test plan
- Reset release, ready=1, 1-cycle memory, id_ready=1 → addresses 0x0,0x4,0x8 requested; id_pc 0x0,0x4,0x8 with matching instr, id_valid first at 3rd cycle after reset release.
- id_ready=0 with DEPTH=2 → two entries queue, no third request, hold_pc=1; release id_ready → entries drain in order, fetch resumes at 0x8.
- Redirect to 0x100 while in S_WAIT, response 2 cycles later → response discarded, next request addr 0x100, id_pc first 0x100.
- Redirect in same cycle as response → response dropped, queue empty, next request 0x100.
- imem_req_ready low for 5 cycles → PC held, imem_req_addr stable, single handshake on ready rise.
- pc_in=0xFFFF_FFFC fetch → next_pc=0x0000_0000.
